// File: rtl/attack_requester.sv
// Initiator side of the attack-evaluation handshake: launches one board at a time,
// captures the evaluator verdict and returns it on a registered valid/ready stream.
// Optional WAIT watchdog is compiled in with `define ATTACK_REQ_TIMEOUT_EN.
module attack_requester #(
    parameter int unsigned BOARD_WIDTH    = 256,
    parameter int unsigned INDEX_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] in_board,
    input  logic                   in_white_to_move,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BOARD_WIDTH-1:0] eval_board,
    output logic                   eval_board_valid,
    output logic                   eval_clear_attack,
    input  logic                   eval_done,
    input  logic                   eval_white_in_check,
    input  logic                   eval_black_in_check,
    input  logic [5:0]             eval_white_pop,
    input  logic [5:0]             eval_black_pop,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [INDEX_WIDTH-1:0] res_index,
    output logic                   res_legal,
    output logic                   res_white_in_check,
    output logic                   res_black_in_check,
    output logic [5:0]             res_white_pop,
    output logic [5:0]             res_black_pop,
    output logic                   res_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CLEAR,
        DRAIN
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] index;
    logic [INDEX_WIDTH-1:0] req_index;
    logic                   white_to_move;

`ifdef ATTACK_REQ_TIMEOUT_EN
    localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [COUNT_WIDTH-1:0] wait_count;
`else
    assign res_timeout = 1'b0;
    // Watchdog compiled out: the parameter is kept only so both builds share one parameter list.
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

    assign in_ready = (state == IDLE) && !res_valid && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            index              <= '0;
            req_index          <= '0;
            white_to_move      <= 1'b0;
            eval_board         <= '0;
            eval_board_valid   <= 1'b0;
            eval_clear_attack  <= 1'b0;
            res_valid          <= 1'b0;
            res_index          <= '0;
            res_legal          <= 1'b0;
            res_white_in_check <= 1'b0;
            res_black_in_check <= 1'b0;
            res_white_pop      <= '0;
            res_black_pop      <= '0;
`ifdef ATTACK_REQ_TIMEOUT_EN
            res_timeout        <= 1'b0;
            wait_count         <= '0;
`endif
        end else begin
            eval_board_valid  <= 1'b0;
            eval_clear_attack <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        eval_board       <= in_board;
                        white_to_move    <= in_white_to_move;
                        req_index        <= index;
                        index            <= index + 1'b1;
                        eval_board_valid <= 1'b1;
                        state            <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef ATTACK_REQ_TIMEOUT_EN
                    wait_count <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (eval_done) begin
                        res_index          <= req_index;
                        // Legal when the side that just moved is not left in check.
                        res_legal          <= white_to_move ? !eval_black_in_check
                                                            : !eval_white_in_check;
                        res_white_in_check <= eval_white_in_check;
                        res_black_in_check <= eval_black_in_check;
                        res_white_pop      <= eval_white_pop;
                        res_black_pop      <= eval_black_pop;
                        res_valid          <= 1'b1;
`ifdef ATTACK_REQ_TIMEOUT_EN
                        res_timeout        <= 1'b0;
`endif
                        state              <= CLEAR;
                    end
`ifdef ATTACK_REQ_TIMEOUT_EN
                    else if (wait_count == TIMEOUT_LAST) begin
                        res_index          <= req_index;
                        res_legal          <= 1'b0;
                        res_white_in_check <= 1'b0;
                        res_black_in_check <= 1'b0;
                        res_white_pop      <= '0;
                        res_black_pop      <= '0;
                        res_valid          <= 1'b1;
                        res_timeout        <= 1'b1;
                        state              <= CLEAR;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
`endif
                end
                CLEAR: begin
                    eval_clear_attack <= 1'b1;
                    state             <= DRAIN;
                end
                DRAIN: begin
                    // A done level still high here belongs to the previous board.
                    if (!eval_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attack_requester.sv
// Randomized bench for attack_requester: a behavioural evaluator plus an event-timed
// transaction model predict every output each cycle; directed phases cover the edge cases.
`timescale 1ns/1ps
module tb_attack_requester;

    localparam int unsigned BW = 256;
    localparam int unsigned IW = 4;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          reset;
    logic [BW-1:0] in_board;
    logic          in_white_to_move;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] eval_board;
    logic          eval_board_valid;
    logic          eval_clear_attack;
    logic          eval_done;
    logic          eval_white_in_check;
    logic          eval_black_in_check;
    logic [5:0]    eval_white_pop;
    logic [5:0]    eval_black_pop;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_index;
    logic          res_legal;
    logic          res_white_in_check;
    logic          res_black_in_check;
    logic [5:0]    res_white_pop;
    logic [5:0]    res_black_pop;
    logic          res_timeout;

    attack_requester #(
        .BOARD_WIDTH   (BW),
        .INDEX_WIDTH   (IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_board           (in_board),
        .in_white_to_move   (in_white_to_move),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .eval_board         (eval_board),
        .eval_board_valid   (eval_board_valid),
        .eval_clear_attack  (eval_clear_attack),
        .eval_done          (eval_done),
        .eval_white_in_check(eval_white_in_check),
        .eval_black_in_check(eval_black_in_check),
        .eval_white_pop     (eval_white_pop),
        .eval_black_pop     (eval_black_pop),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_index          (res_index),
        .res_legal          (res_legal),
        .res_white_in_check (res_white_in_check),
        .res_black_in_check (res_black_in_check),
        .res_white_pop      (res_white_pop),
        .res_black_pop      (res_black_pop),
        .res_timeout        (res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: what the requester owes, derived from transaction events.
    int            m_idx;
    int unsigned   m_tag;
    logic          m_wtm;
    logic [BW-1:0] m_board;
    bit            inflight, waiting, drain_m;
    int            pulse_cyc, clr_cyc;
    bit            e_ir, e_rv, e_ebv;
    logic [63:0]   e_pay;
    logic [63:0]   last_pay;

    // Behavioural evaluator state and knobs.
    int         ev_st, ev_cnt;
    bit         ev_rose, ev_mute;
    logic       ev_wic, ev_bic;
    logic [5:0] ev_wp, ev_bp;
    bit         fx_en;
    int         fx_lat, fx_hold;
    logic       fx_wic, fx_bic;
    logic [5:0] fx_wp, fx_bp;

    // Stimulus knobs.
    int   want;
    bit   rnd_valid;
    int   rr_mode;
    bit   fx_wtm_en;
    logic fx_wtm;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Layout: [31:16] index, [15] legal, [14] white chk, [13] black chk, [12:7] wpop, [6:1] bpop, [0] timeout
    function automatic logic [63:0] pack(input int unsigned idx, input logic legal, input logic wic,
                                         input logic bic, input logic [5:0] wp, input logic [5:0] bp,
                                         input logic to);
        return {32'd0, 16'(idx), legal, wic, bic, wp, bp, to};
    endfunction

    function automatic logic [63:0] obs_payload();
        return pack(int'(res_index), res_legal, res_white_in_check, res_black_in_check,
                    res_white_pop, res_black_pop, res_timeout);
    endfunction

    task automatic step();
        logic acc, to_event;
        @(negedge clk);
        cyc++;
        check_eq("in_ready", in_ready, e_ir);
        check_eq("eval_board_valid", eval_board_valid, e_ebv);
        check_eq("eval_clear_attack", eval_clear_attack, (cyc == clr_cyc));
        check_eq("res_valid", res_valid, e_rv);
        if (e_rv) check_eq("res_payload", obs_payload(), e_pay);
        check_eq("eval_board_match", (eval_board == m_board), 1'b1);

        // Evaluator reacts to what the requester drives this cycle.
        ev_rose = 1'b0;
        if (eval_board_valid) begin
            ev_cnt = fx_en ? fx_lat : int'($urandom_range(1, 6));
            ev_st  = 1;
        end else begin
            case (ev_st)
                1: begin
                    ev_cnt--;
                    if (ev_cnt == 0) begin
                        if (ev_mute) ev_st = 0;
                        else begin
                            ev_wic  = fx_en ? fx_wic : ($urandom_range(0, 3) == 0);
                            ev_bic  = fx_en ? fx_bic : ($urandom_range(0, 3) == 0);
                            ev_wp   = fx_en ? fx_wp : 6'($urandom);
                            ev_bp   = fx_en ? fx_bp : 6'($urandom);
                            eval_done           = 1'b1;
                            eval_white_in_check = ev_wic;
                            eval_black_in_check = ev_bic;
                            eval_white_pop      = ev_wp;
                            eval_black_pop      = ev_bp;
                            ev_rose = 1'b1;
                            ev_st   = 2;
                        end
                    end
                end
                2: if (eval_clear_attack) begin
                    ev_cnt = fx_en ? fx_hold : int'($urandom_range(0, 3));
                    if (ev_cnt == 0) begin eval_done = 1'b0; ev_st = 0; end
                    else ev_st = 3;
                end
                3: begin
                    ev_cnt--;
                    if (ev_cnt == 0) begin eval_done = 1'b0; ev_st = 0; end
                end
                default: ;
            endcase
        end
        if (!eval_done) begin
            eval_white_in_check = 1'($urandom);
            eval_black_in_check = 1'($urandom);
            eval_white_pop      = 6'($urandom);
            eval_black_pop      = 6'($urandom);
        end

        res_ready = (rr_mode == 2) ? 1'($urandom) : (rr_mode == 1);
        in_valid  = (want > 0) && (!rnd_valid || $urandom_range(0, 2) != 0);
        for (int unsigned i = 0; i < BW / 32; i++) in_board[i*32 +: 32] = $urandom;
        in_white_to_move = fx_wtm_en ? fx_wtm : 1'($urandom);

        // Predict the next cycle.
        acc = e_ir && in_valid;
        to_event = 1'b0;
`ifdef ATTACK_REQ_TIMEOUT_EN
        to_event = waiting && !ev_rose && (cyc == pulse_cyc + int'(TO));
`endif
        if (e_rv && res_ready) last_pay = obs_payload();
        e_rv = e_rv && !res_ready;
        if (waiting && (ev_rose || to_event)) begin
            e_rv    = 1'b1;
            waiting = 1'b0;
            clr_cyc = cyc + 2;
            if (to_event) e_pay = pack(m_tag, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
            else e_pay = pack(m_tag, !(m_wtm ? ev_bic : ev_wic), ev_wic, ev_bic, ev_wp, ev_bp, 1'b0);
        end
        if (cyc == clr_cyc) drain_m = 1'b1;
        if (drain_m && !eval_done) begin
            drain_m  = 1'b0;
            inflight = 1'b0;
        end
        e_ebv = acc;
        if (acc) begin
            inflight  = 1'b1;
            waiting   = 1'b1;
            m_board   = in_board;
            m_wtm     = in_white_to_move;
            m_tag     = m_idx % (1 << IW);
            m_idx++;
            pulse_cyc = cyc + 1;
            want--;
        end
        e_ir = !inflight && !e_rv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0; res_ready = 1'b0; eval_done = 1'b0;
        eval_white_in_check = 1'b0; eval_black_in_check = 1'b0;
        eval_white_pop = '0; eval_black_pop = '0;
        #1;
        check_eq("reset_outputs", {in_ready, eval_board_valid, eval_clear_attack, res_valid, obs_payload()}, '0);
        check_eq("reset_eval_board", (eval_board == '0), 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_idx = 0; m_tag = 0; m_board = '0; want = 0;
        inflight = 0; waiting = 0; drain_m = 0;
        e_ir = 1; e_rv = 0; e_ebv = 0;
        clr_cyc = -100; pulse_cyc = -100;
        ev_st = 0; ev_cnt = 0;
    endtask

    task automatic run_until_idle(input string tag, input int limit);
        int n = 0;
        while ((want > 0 || inflight || e_rv) && n < limit) begin
            step();
            n++;
        end
        check_eq(tag, (want > 0 || inflight || e_rv), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_board = '0; in_white_to_move = 1'b0;
        eval_done = 1'b0; eval_white_in_check = 1'b0; eval_black_in_check = 1'b0;
        eval_white_pop = '0; eval_black_pop = '0;
        ev_mute = 0; rnd_valid = 0; rr_mode = 1;
        fx_en = 1; fx_lat = 4; fx_hold = 0; fx_wic = 0; fx_bic = 0; fx_wp = 6'd12; fx_bp = 6'd9;
        fx_wtm_en = 1; fx_wtm = 1'b1;
        last_pay = '0;
        do_reset();

        // Single board, done 4 cycles after the start pulse.
        want = 1;
        run_until_idle("t1_idle", 40);
        check_eq("t1_result", last_pay, pack(0, 1'b1, 1'b0, 1'b0, 6'd12, 6'd9, 1'b0));

        // Legality depends on who just moved.
        fx_bic = 1'b1; fx_wtm = 1'b1; want = 1;
        run_until_idle("t2a_idle", 40);
        check_eq("legal_black_moved_black_checked", last_pay[15], 1'b0);
        fx_wtm = 1'b0; want = 1;
        run_until_idle("t2b_idle", 40);
        check_eq("legal_white_moved_black_checked", last_pay[15], 1'b1);

        // Back-pressure: result held for 20 cycles, next board waits for the ready pulse.
        fx_bic = 1'b0; fx_lat = 3; rr_mode = 0; want = 2;
        n = 0;
        while (!e_rv && n < 40) begin step(); n++; end
        check_eq("t3_result_seen", e_rv, 1'b1);
        repeat (20) step();
        check_eq("t3_no_accept_while_pending", want, 1);
        rr_mode = 1; step();
        rr_mode = 0; step();
        check_eq("t3_accept_after_ready", want, 0);
        rr_mode = 1;
        run_until_idle("t3_idle", 40);

        // Stale done held after clear must not launch the next board early.
        do_reset();
        fx_hold = 3; want = 2;
        run_until_idle("t4_idle", 60);
        check_eq("t4_second_index", last_pay[31:16], 16'd1);

        // Random traffic, covers index wrap.
        fx_en = 0; fx_wtm_en = 0; rnd_valid = 1; rr_mode = 2; want = 1000;
        repeat (600) step();
        want = 0; rr_mode = 1;
        run_until_idle("t5_idle", 60);

        // Reset during WAIT discards the board and restarts the index.
        fx_en = 1; fx_lat = 6; fx_hold = 0; rnd_valid = 0; want = 1;
        n = 0;
        while (!(waiting && ev_st == 1 && cyc > pulse_cyc) && n < 40) begin step(); n++; end
        check_eq("t6_reached_wait", (waiting && ev_st == 1), 1'b1);
        do_reset();
        fx_lat = 2; want = 1;
        run_until_idle("t6_idle", 40);
        check_eq("t6_index_restart", last_pay[31:16], 16'd0);

`ifdef ATTACK_REQ_TIMEOUT_EN
        // Evaluator never answers: watchdog result, then normal service resumes.
        ev_mute = 1; want = 1;
        run_until_idle("t7_idle", 60);
        check_eq("t7_timeout_flag", last_pay[0], 1'b1);
        check_eq("t7_timeout_legal", last_pay[15], 1'b0);
        ev_mute = 0; want = 1;
        run_until_idle("t7_resume_idle", 40);
        check_eq("t7_resume_no_timeout", last_pay[0], 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
